// File: rtl/xphy_pkg.sv
// rtl/xphy_pkg.sv - shared PHY sequencer state encodings and width helpers
package xphy_pkg;

  localparam logic [2:0] ST_WAIT_QPLL = 3'd0;
  localparam logic [2:0] ST_MMCM_RST  = 3'd1;
  localparam logic [2:0] ST_WAIT_MMCM = 3'd2;
  localparam logic [2:0] ST_GT_RST    = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_RUN       = 3'd5;
  localparam logic [2:0] ST_FAIL      = 3'd6;

  // Number of bits needed to index 'value' items; never less than 1.
  function automatic int unsigned xphy_clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Largest of three cycle counts, used to size the shared state counter.
  function automatic int unsigned xphy_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/xphy_sync.sv
// rtl/xphy_sync.sv - multi-bit multi-stage flop synchroniser for async status inputs
module xphy_sync #(
  parameter int C_WIDTH  = 1,
  parameter int C_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [C_WIDTH-1:0] d_i,
  output logic [C_WIDTH-1:0] q_o
);

  logic [C_WIDTH-1:0] stage_q [C_STAGES];

  // Shift each bit through the flop chain; reset to 0 so nothing looks locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < C_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[C_STAGES-1];

endmodule

// File: rtl/xphy_clk_reset_seq.sv
// rtl/xphy_clk_reset_seq.sv - QPLL/MMCM/GT reset sequencer with timeout retry and lock-loss recovery
module xphy_clk_reset_seq
  import xphy_pkg::*;
#(
  parameter int C_CHANNELS        = 1,
  parameter int C_SYNC_STAGES     = 2,
  parameter int C_MMCM_RST_CYCLES = 16,
  parameter int C_GT_RST_CYCLES   = 32,
  parameter int C_LOCK_TIMEOUT    = 65536,
  parameter int C_MAX_RETRY       = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    qplllock_i,
  input  logic                                    mmcm_locked_i,
  input  logic [C_CHANNELS-1:0]                   resetdone_i,
  output logic                                    mmcm_rst_o,
  output logic [C_CHANNELS-1:0]                   gt_rst_o,
  output logic [C_CHANNELS-1:0]                   core_rst_n_o,
  output logic                                    ready_o,
  output logic                                    fail_o,
  output logic [xphy_clog2(C_MAX_RETRY+1)-1:0]    retry_cnt_o,
  output logic [2:0]                              state_o
);

  localparam int CNT_W = xphy_clog2(xphy_max3(C_MMCM_RST_CYCLES, C_GT_RST_CYCLES,
                                              C_LOCK_TIMEOUT) + 1);
  localparam int RTY_W = xphy_clog2(C_MAX_RETRY + 1);
  localparam int SYN_W = C_CHANNELS + 2;

  localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(C_MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GT_LAST      = CNT_W'(C_GT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(C_LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RETRY_LAST   = RTY_W'(C_MAX_RETRY - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(C_MAX_RETRY);

  logic [SYN_W-1:0]      sync_q;
  logic                  qpll_s;
  logic                  mmcm_s;
  logic [C_CHANNELS-1:0] done_s;

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [2:0]            adv_state;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [RTY_W-1:0]      retry_q;
  logic [RTY_W-1:0]      retry_d;
  logic                  timeout;
  logic                  qpll_loss;
  logic                  mmcm_loss;
  logic                  counting;

  xphy_sync #(
    .C_WIDTH  (SYN_W),
    .C_STAGES (C_SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({resetdone_i, mmcm_locked_i, qplllock_i}),
    .q_o   (sync_q)
  );

  assign qpll_s = sync_q[0];
  assign mmcm_s = sync_q[1];
  assign done_s = sync_q[SYN_W-1:2];

  assign qpll_loss = !qpll_s && (state_q != ST_WAIT_QPLL) && (state_q != ST_FAIL);
  assign mmcm_loss = !mmcm_s && ((state_q == ST_GT_RST) || (state_q == ST_WAIT_DONE) ||
                                 (state_q == ST_RUN));

  // Normal forward progress and timeout detection for the current state.
  always_comb begin
    adv_state = state_q;
    timeout   = 1'b0;
    case (state_q)
      ST_WAIT_QPLL: begin
        if (qpll_s) adv_state = ST_MMCM_RST;
      end
      ST_MMCM_RST: begin
        if (cnt_q == MMCM_LAST) adv_state = ST_WAIT_MMCM;
      end
      ST_WAIT_MMCM: begin
        if (mmcm_s) adv_state = ST_GT_RST;
        else if (cnt_q == TIMEOUT_LAST) timeout = 1'b1;
      end
      ST_GT_RST: begin
        if (cnt_q == GT_LAST) adv_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (&done_s) adv_state = ST_RUN;
        else if (cnt_q == TIMEOUT_LAST) timeout = 1'b1;
      end
      ST_RUN:  adv_state = ST_RUN;
      ST_FAIL: adv_state = ST_FAIL;
      default: adv_state = ST_WAIT_QPLL;
    endcase
  end

  // Resolve lock loss, timeout retry and advance in priority order.
  always_comb begin
    state_d = adv_state;
    retry_d = retry_q;
    if (qpll_loss) begin
      state_d = ST_WAIT_QPLL;
    end else if (mmcm_loss) begin
      state_d = ST_MMCM_RST;
    end else if (timeout) begin
      if (retry_q == RETRY_LAST) begin
        state_d = ST_FAIL;
        retry_d = RETRY_MAX;
      end else begin
        state_d = ST_WAIT_QPLL;
        retry_d = retry_q + RTY_W'(1);
      end
    end else if (adv_state == ST_RUN) begin
      retry_d = '0;
    end
  end

  // State cycle counter: cleared on every state change, runs only in timed states.
  always_comb begin
    counting = (state_q == ST_MMCM_RST) || (state_q == ST_WAIT_MMCM) ||
               (state_q == ST_GT_RST)   || (state_q == ST_WAIT_DONE);
    if (state_d != state_q) cnt_d = '0;
    else if (counting)      cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = '0;
  end

  // Register state and derive every output from the next state so they switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_QPLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      mmcm_rst_o   <= 1'b1;
      gt_rst_o     <= '1;
      core_rst_n_o <= '0;
      ready_o      <= 1'b0;
      fail_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      mmcm_rst_o   <= (state_d == ST_WAIT_QPLL) || (state_d == ST_MMCM_RST) ||
                      (state_d == ST_FAIL);
      gt_rst_o     <= ((state_d == ST_WAIT_DONE) || (state_d == ST_RUN)) ? '0 : '1;
      core_rst_n_o <= (state_d == ST_RUN) ? done_s : '0;
      ready_o      <= (state_d == ST_RUN) && (&done_s);
      fail_o       <= (state_d == ST_FAIL);
    end
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule
